// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding
// a circular instruction queue, with redirect flush and sticky error.
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   imem_req/addr/rdy          fetch request channel
//   imem_valid/data            fetch response channel
//   redirect/redirect_pc       branch/jump redirect strobe and target
//   halt                       blocks new requests only
//   inst_valid/inst/inst_pc    queue head toward decode
//   inst_ready                 decode consumes the head
//   err                        sticky unsolicited-response flag
module fetch_unit #(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_rdy,
   input  logic             imem_valid,
   input  logic [WIDTH-1:0] imem_data,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             halt,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst,
   output logic [WIDTH-1:0] inst_pc,
   input  logic             inst_ready,
   output logic             err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] req_pc_q, req_pc_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] qpc_q  [DEPTH];
   logic [WIDTH-1:0] qdat_q [DEPTH];

   logic hs, push, pop;

   // Requests only leave REQ, so no slot is ever in flight while
   // count is compared; a response therefore always finds room.
   assign imem_req  = (state_q == S_REQ) && !halt && !redirect
                    && (cnt_q < FULL);
   assign imem_addr = pc_q;

   assign hs   = imem_req && imem_rdy;
   assign push = (state_q == S_WAIT) && imem_valid && !redirect;
   assign pop  = (cnt_q != '0) && inst_ready && !redirect;

   assign inst_valid = (cnt_q != '0);
   assign inst       = qdat_q[rptr_q];
   assign inst_pc    = qpc_q[rptr_q];
   assign err        = err_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q | (imem_valid && (state_q == S_REQ));
      if (redirect) begin
         // Flush wins over any push or pop this cycle.
         pc_d   = redirect_pc;
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
         case (state_q)
            S_WAIT:  state_d = imem_valid ? S_REQ : S_DROP;
            S_DROP:  state_d = S_DROP;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (hs) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + WIDTH'(2);
                  state_d  = S_WAIT;
               end
            end
            S_WAIT:  if (imem_valid) state_d = S_REQ;
            S_DROP:  if (imem_valid) state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: count gates visibility of every entry.
   always_ff @(posedge clk) begin
      if (push) begin
         qpc_q[wptr_q]  <= req_pc_q;
         qdat_q[wptr_q] <= imem_data;
      end
   end

endmodule
